// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the IF/ID record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // IF/ID pipeline record, also consumed by decode
  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t npc;
  } ifid_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction cache request/response bundle between fetch and icache.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;

  modport master (output iREN, iaddr, input ihit, iload);
  modport slave  (input iREN, iaddr, output ihit, iload);
endinterface

// File: rtl/fetch_unit_skid_buf.sv
// One-entry holding register for an instruction that returns while decode stalls.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load,
  input  logic  clear,
  input  ifid_t d,
  output ifid_t q,
  output logic  full
);

  assign full = q.valid;

  // load wins over clear; the caller never asserts both
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      q <= '0;
    else if (load)  q <= d;
    else if (clear) q <= '0;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage + IF/ID register: PC, icache request, one-deep skid, redirect, halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = PC_INIT_DEFAULT,
  parameter int unsigned PC_STEP = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  fetch_unit_if.master ic,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt_dec,
  output logic  instr_valid,
  output word_t instr,
  output word_t instr_npc,
  output logic  halted
);

  word_t        pc, pc_n, pc_inc;
  fetch_state_t state, state_n;
  ifid_t        ifid, ifid_n;
  logic         halted_n;
  logic         skid_load, skid_clear, skid_full;
  ifid_t        skid_d, skid_q;

  assign pc_inc      = pc + word_t'(PC_STEP);
  assign ic.iREN     = (state == FETCH);
  assign ic.iaddr    = pc;
  assign instr_valid = ifid.valid;
  assign instr       = ifid.instr;
  assign instr_npc   = ifid.npc;
  assign skid_d      = '{valid: 1'b1, instr: ic.iload, npc: pc_inc};

  fetch_skid_buf u_skid (
    .CLK  (CLK),
    .nRST (nRST),
    .load (skid_load),
    .clear(skid_clear),
    .d    (skid_d),
    .q    (skid_q),
    .full (skid_full)
  );

  // next-state: redirect > halt > stall > ihit
  always_comb begin
    pc_n       = pc;
    state_n    = state;
    ifid_n     = ifid;
    halted_n   = halted;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (state != HALTED) begin
      if (redirect) begin
        // wrong-path HALT and any returning word are dropped
        pc_n         = redirect_pc;
        ifid_n.valid = 1'b0;
        skid_clear   = 1'b1;
        state_n      = FETCH;
      end else if (halt_dec && ifid.valid) begin
        state_n      = HALTED;
        halted_n     = 1'b1;
        ifid_n.valid = 1'b0;
        skid_clear   = 1'b1;
      end else if (state == HOLD) begin
        if (!stall && skid_full) begin
          ifid_n     = skid_q;
          skid_clear = 1'b1;
          state_n    = FETCH;
        end
      end else if (stall) begin
        // early return while decode is stalled: park it, stop requesting
        if (ic.ihit) begin
          skid_load = 1'b1;
          pc_n      = pc_inc;
          state_n   = HOLD;
        end
      end else if (ic.ihit) begin
        ifid_n = '{valid: 1'b1, instr: ic.iload, npc: pc_inc};
        pc_n   = pc_inc;
      end else begin
        ifid_n.valid = 1'b0;
      end
    end
  end

  // pc, FSM state, IF/ID and sticky halt
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc     <= PC_INIT;
      state  <= FETCH;
      ifid   <= '0;
      halted <= 1'b0;
    end else begin
      pc     <= pc_n;
      state  <= state_n;
      ifid   <= ifid_n;
      halted <= halted_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, skid, redirect, halt, wrap, reset.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  stall, redirect, halt_dec;
  word_t redirect_pc;
  logic  instr_valid, halted;
  word_t instr, instr_npc;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  fetch_unit_if ic ();

  fetch_unit #(.PC_INIT(32'h0), .PC_STEP(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ic         (ic.master),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_dec   (halt_dec),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_npc  (instr_npc),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect = 0; halt_dec = 0; redirect_pc = '0;
    ic.ihit = 0; ic.iload = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    step();
    nRST = 1;
  endtask

  task automatic fetch_one(input word_t w);
    ic.ihit = 1; ic.iload = w;
    step();
    ic.ihit = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 0;
    #2;
    total_cnt++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_npc !== 32'h0 || halted !== 1'b0)
      $display("FAIL reset_outputs: valid=%b instr=%h npc=%h halted=%b, want 0/0/0/0",
               instr_valid, instr, instr_npc, halted);
    else pass_cnt++;
    total_cnt++;
    if (ic.iREN !== 1'b1 || ic.iaddr !== 32'h0)
      $display("FAIL reset_req: iREN=%b iaddr=%h, want 1/0", ic.iREN, ic.iaddr);
    else pass_cnt++;
    step();
    nRST = 1;
  endtask

  task automatic test_sequential();
    word_t words [3] = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ic.iaddr !== word_t'(4 * i))
        $display("FAIL seq_iaddr%0d: got %h, want %h", i, ic.iaddr, 4 * i);
      else pass_cnt++;
      fetch_one(words[i]);
      total_cnt++;
      if (instr_valid !== 1'b1 || instr !== words[i] || instr_npc !== word_t'(4 * (i + 1)))
        $display("FAIL seq_ifid%0d: valid=%b instr=%h npc=%h, want 1/%h/%h",
                 i, instr_valid, instr, instr_npc, words[i], 4 * (i + 1));
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (instr_valid !== 1'b0 || ic.iaddr !== 32'hC)
      $display("FAIL seq_bubble: valid=%b iaddr=%h, want 0/c", instr_valid, ic.iaddr);
    else pass_cnt++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    fetch_one(32'h2001_0001);
    stall = 1; ic.ihit = 1; ic.iload = 32'h2002_0002;
    step();
    total_cnt++;
    if (instr !== 32'h2001_0001 || instr_npc !== 32'h4 || ic.iREN !== 1'b0 || ic.iaddr !== 32'h8)
      $display("FAIL skid_capture: instr=%h npc=%h iREN=%b iaddr=%h, want 20010001/4/0/8",
               instr, instr_npc, ic.iREN, ic.iaddr);
    else pass_cnt++;
    ic.iload = 32'hBAD0_BAD0;
    step();
    total_cnt++;
    if (instr !== 32'h2001_0001 || ic.iREN !== 1'b0 || ic.iaddr !== 32'h8)
      $display("FAIL skid_hold: instr=%h iREN=%b iaddr=%h, want 20010001/0/8",
               instr, ic.iREN, ic.iaddr);
    else pass_cnt++;
    stall = 0; ic.ihit = 0;
    step();
    total_cnt++;
    if (instr_valid !== 1'b1 || instr !== 32'h2002_0002 || instr_npc !== 32'h8 ||
        ic.iREN !== 1'b1 || ic.iaddr !== 32'h8)
      $display("FAIL skid_release: valid=%b instr=%h npc=%h iREN=%b iaddr=%h, want 1/20020002/8/1/8",
               instr_valid, instr, instr_npc, ic.iREN, ic.iaddr);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) fetch_one(32'h1000_0000 + i);
    redirect = 1; redirect_pc = 32'h40; ic.ihit = 1; ic.iload = 32'hDEAD_BEEF;
    step();
    total_cnt++;
    if (instr_valid !== 1'b0 || ic.iaddr !== 32'h40)
      $display("FAIL redirect_flush: valid=%b iaddr=%h, want 0/40", instr_valid, ic.iaddr);
    else pass_cnt++;
    redirect = 0; ic.iload = 32'h1111_1111;
    step();
    ic.ihit = 0;
    total_cnt++;
    if (instr !== 32'h1111_1111 || instr_npc !== 32'h44 || instr_valid !== 1'b1)
      $display("FAIL redirect_target: instr=%h npc=%h valid=%b, want 11111111/44/1",
               instr, instr_npc, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    fetch_one(32'hFFFF_FFFF);
    halt_dec = 1; ic.ihit = 1; ic.iload = 32'h2222_2222;
    step();
    halt_dec = 0;
    total_cnt++;
    if (halted !== 1'b1 || ic.iREN !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL halt_enter: halted=%b iREN=%b valid=%b, want 1/0/0",
               halted, ic.iREN, instr_valid);
    else pass_cnt++;
    redirect = 1; redirect_pc = 32'h100;
    step();
    redirect = 0;
    step(); step();
    total_cnt++;
    if (halted !== 1'b1 || ic.iREN !== 1'b0 || instr_valid !== 1'b0 || ic.iaddr !== 32'h4)
      $display("FAIL halt_sticky: halted=%b iREN=%b valid=%b iaddr=%h, want 1/0/0/4",
               halted, ic.iREN, instr_valid, ic.iaddr);
    else pass_cnt++;
    ic.ihit = 0;
  endtask

  task automatic test_redirect_beats_halt();
    do_reset();
    fetch_one(32'hFFFF_FFFF);
    halt_dec = 1; redirect = 1; redirect_pc = 32'h80;
    step();
    halt_dec = 0; redirect = 0;
    total_cnt++;
    if (halted !== 1'b0 || ic.iREN !== 1'b1 || ic.iaddr !== 32'h80 || instr_valid !== 1'b0)
      $display("FAIL redirect_over_halt: halted=%b iREN=%b iaddr=%h valid=%b, want 0/1/80/0",
               halted, ic.iREN, ic.iaddr, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    total_cnt++;
    if (ic.iaddr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_setup: iaddr=%h, want fffffffc", ic.iaddr);
    else pass_cnt++;
    fetch_one(32'h3333_3333);
    total_cnt++;
    if (ic.iaddr !== 32'h0 || instr_npc !== 32'h0 || instr !== 32'h3333_3333)
      $display("FAIL wrap_pc: iaddr=%h npc=%h instr=%h, want 0/0/33333333",
               ic.iaddr, instr_npc, instr);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    fetch_one(32'h5555_5555);
    stall = 1; ic.ihit = 1; ic.iload = 32'h6666_6666;
    step();
    ic.ihit = 0;
    total_cnt++;
    if (ic.iREN !== 1'b0)
      $display("FAIL hold_entry: iREN=%b, want 0", ic.iREN);
    else pass_cnt++;
    nRST = 0;
    #1;
    total_cnt++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_npc !== 32'h0 ||
        ic.iREN !== 1'b1 || ic.iaddr !== 32'h0 || halted !== 1'b0)
      $display("FAIL async_reset: valid=%b instr=%h npc=%h iREN=%b iaddr=%h halted=%b, want 0/0/0/1/0/0",
               instr_valid, instr, instr_npc, ic.iREN, ic.iaddr, halted);
    else pass_cnt++;
    step();
    nRST = 1; stall = 0;
    step();
    total_cnt++;
    if (instr_valid !== 1'b0 || ic.iaddr !== 32'h0)
      $display("FAIL skid_lost: valid=%b iaddr=%h, want 0/0", instr_valid, ic.iaddr);
    else pass_cnt++;
    fetch_one(32'h4444_4444);
    total_cnt++;
    if (instr !== 32'h4444_4444 || instr_npc !== 32'h4 || instr_valid !== 1'b1)
      $display("FAIL post_reset_fetch: instr=%h npc=%h valid=%b, want 44444444/4/1",
               instr, instr_npc, instr_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect();
    test_halt();
    test_redirect_beats_halt();
    test_wrap();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
